// File: rtl/ifid_stage_buf.sv
// ifid_stage_buf -- IF/ID pipeline stage with a 2-entry elastic (skid) buffer.
//
// Carries {PC+4, instruction} from fetch to decode behind a valid/ready
// handshake. A head slot drives the outputs and a skid slot absorbs one extra
// entry. Because of the skid slot, in_ready is a function of the state
// register and IFWrite only, so there is no combinational path from
// out_ready back to in_ready.
// All state updates happen on the falling edge of CLK.
//
// Ports
//   CLK, RST_n              clock (negedge active), async active-low reset
//   IFWrite                 0 = freeze the stage (no accept, no release)
//   Flush                   drop every held entry at this edge (acts even when IFWrite = 0)
//   in_valid/in_ready       fetch-side handshake; PC_4, Instr are the payload
//   out_valid/out_ready     decode-side handshake; PC_4_IFID, Instr_IFID are the head
//   stall_cnt, flush_cnt    saturating performance counters (IFID_PERF_EN only)
//
// Configuration macro: IFID_PERF_EN adds the CNT_W parameter and the
// stall_cnt / flush_cnt outputs. Without it those do not exist.
module ifid_stage_buf #(
    parameter int                 PC_W         = 32,
    parameter int                 INSTR_W      = 32,
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = {INSTR_W{1'b0}}
`ifdef IFID_PERF_EN
    ,
    parameter int                 CNT_W        = 16
`endif
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               IFWrite,
    input  logic               Flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    PC_4,
    input  logic [INSTR_W-1:0] Instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    PC_4_IFID,
    output logic [INSTR_W-1:0] Instr_IFID
`ifdef IFID_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t             state, state_nxt;
    logic               acc, rel;
    logic [PC_W-1:0]    head_pc, skid_pc;
    logic [INSTR_W-1:0] head_instr, skid_instr;

    // State register
    always_ff @(negedge CLK or negedge RST_n) begin
        if (!RST_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Next-state logic; Flush overrides any accept or release on the same edge
    always_comb begin
        state_nxt = state;
        if (Flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (acc) state_nxt = ONE;
                ONE: begin
                    if (acc && !rel)      state_nxt = TWO;
                    else if (rel && !acc) state_nxt = EMPTY;
                end
                TWO:     if (rel) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake outputs, decoded from the registered state only
    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = IFWrite && (state != TWO);
        acc       = in_valid && in_ready;
        rel       = out_valid && out_ready && IFWrite;
    end

    // Datapath. With IFWrite = 0 both acc and rel are 0, so every slot holds.
    always_ff @(negedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            head_pc    <= '0;
            head_instr <= BUBBLE_INSTR;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (Flush) begin
            head_pc    <= '0;
            head_instr <= BUBBLE_INSTR;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        head_pc    <= PC_4;
                        head_instr <= Instr;
                    end
                end
                ONE: begin
                    if (acc && rel) begin
                        head_pc    <= PC_4;
                        head_instr <= Instr;
                    end else if (acc) begin
                        skid_pc    <= PC_4;
                        skid_instr <= Instr;
                    end else if (rel) begin
                        // Going empty: show a NOP, leave the last PC visible
                        head_instr <= BUBBLE_INSTR;
                    end
                end
                TWO: begin
                    if (rel) begin
                        head_pc    <= skid_pc;
                        head_instr <= skid_instr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign PC_4_IFID  = head_pc;
    assign Instr_IFID = head_instr;

`ifdef IFID_PERF_EN
    // Saturating counters; Flush does not clear them
    logic stall_ev;
    assign stall_ev = out_valid && !(out_ready && IFWrite);

    always_ff @(negedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
            if (Flush && (flush_cnt != {CNT_W{1'b1}}))    flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ifid_stage_buf.sv
// Self-checking bench for ifid_stage_buf. A reference queue holds the entries
// the stage should contain; entries are pushed when the bench offers a word
// the model says will be accepted, and popped/compared when released.
module tb_ifid_stage_buf;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    logic               CLK = 1'b0;
    logic               RST_n, IFWrite, Flush, in_valid, out_ready;
    logic               in_ready, out_valid;
    logic [PC_W-1:0]    PC_4, PC_4_IFID;
    logic [INSTR_W-1:0] Instr, Instr_IFID;
    logic [INSTR_W-1:0] bubble;

`ifdef IFID_PERF_EN
    logic [1:0] stall_cnt, flush_cnt;
    int         m_stall, m_flush;
`endif

    always #5 CLK = ~CLK;

    ifid_stage_buf #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .BUBBLE_INSTR({INSTR_W{1'b0}})
`ifdef IFID_PERF_EN
        , .CNT_W(2)
`endif
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .IFWrite(IFWrite), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready), .PC_4(PC_4), .Instr(Instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .PC_4_IFID(PC_4_IFID), .Instr_IFID(Instr_IFID)
`ifdef IFID_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] ins;
    } ent_t;

    ent_t            q[$];
    logic [PC_W-1:0] last_pc;
    int              total = 0;
    int              bad   = 0;

    // One negedge of the DUT: drive inputs, check outputs against the model,
    // advance the model, then step to just after the active edge.
    task automatic cycle(input bit iv, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                         input bit ordy, input bit ifw, input bit fl);
        bit   exp_rdy, rel, acc;
        ent_t e;
        in_valid = iv; PC_4 = pc; Instr = ins; out_ready = ordy; IFWrite = ifw; Flush = fl;
        #1;
        exp_rdy = ifw && (q.size() < 2);
        total++;
        if (in_ready !== exp_rdy) begin
            bad++; $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_rdy);
        end
        total++;
        if (out_valid !== (q.size() > 0)) begin
            bad++; $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, q.size() > 0);
        end
        total++;
        if (q.size() > 0) begin
            if (PC_4_IFID !== q[0].pc || Instr_IFID !== q[0].ins) begin
                bad++; $display("FAIL head t=%0t got=%h/%h exp=%h/%h", $time, PC_4_IFID, Instr_IFID, q[0].pc, q[0].ins);
            end
        end else begin
            if (PC_4_IFID !== last_pc || Instr_IFID !== bubble) begin
                bad++; $display("FAIL empty_out t=%0t got=%h/%h exp=%h/%h", $time, PC_4_IFID, Instr_IFID, last_pc, bubble);
            end
        end
`ifdef IFID_PERF_EN
        total++;
        if (stall_cnt !== m_stall[1:0] || flush_cnt !== m_flush[1:0]) begin
            bad++; $display("FAIL perf t=%0t got=%0d/%0d exp=%0d/%0d", $time, stall_cnt, flush_cnt, m_stall, m_flush);
        end
        if (q.size() > 0 && !(ordy && ifw) && m_stall < 3) m_stall++;
        if (fl && m_flush < 3) m_flush++;
`endif
        if (fl) begin
            q.delete();
            last_pc = '0;
        end else begin
            rel = (q.size() > 0) && ordy && ifw;
            acc = iv && exp_rdy;
            if (rel) begin
                e = q.pop_front();
                last_pc = e.pc;
            end
            if (acc) q.push_back('{pc, ins});
        end
        @(negedge CLK); #1;
    endtask

    // Asynchronous reset applied between edges
    task automatic do_reset();
        RST_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || Instr_IFID !== bubble || PC_4_IFID !== '0) begin
            bad++; $display("FAIL reset_out got v=%b %h/%h exp v=0 0/0", out_valid, PC_4_IFID, Instr_IFID);
        end
        q.delete();
        last_pc = '0;
`ifdef IFID_PERF_EN
        m_stall = 0; m_flush = 0;
`endif
        in_valid = 1'b0; Flush = 1'b0; out_ready = 1'b0;
        @(negedge CLK); #2;
        RST_n = 1'b1;
        IFWrite = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL rdy_after_rst_ifw0 got=%b exp=0", in_ready);
        end
        IFWrite = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rdy_after_rst_ifw1 got=%b exp=1", in_ready);
        end
        @(negedge CLK); #1;
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1, 32'h100, 32'hdead_0001, 0, 1, 0);
        cycle(1, 32'h104, 32'hdead_0002, 0, 1, 0);
        cycle(0, 32'h0, 32'h0, 0, 1, 0);
        do_reset();  // mid-stream, two entries held
        cycle(0, 32'h0, 32'h0, 1, 1, 0);
    endtask

    task automatic test_streaming();
        cycle(1, 32'd4,  32'h0000_0413, 1, 1, 0);
        cycle(1, 32'd8,  32'h0010_0093, 1, 1, 0);
        cycle(1, 32'd12, 32'h0020_0113, 1, 1, 0);
        cycle(0, 32'd0,  32'h0, 1, 1, 0);
        cycle(0, 32'd0,  32'h0, 1, 1, 0);
    endtask

    task automatic test_backpressure();
        cycle(1, 32'h10, 32'haaaa_0010, 0, 1, 0);
        cycle(1, 32'h14, 32'haaaa_0014, 0, 1, 0);
        cycle(1, 32'h18, 32'haaaa_0018, 0, 1, 0);  // stage full, must not be taken
        cycle(0, 32'h0,  32'h0, 1, 1, 0);
        cycle(0, 32'h0,  32'h0, 1, 1, 0);
        cycle(0, 32'h0,  32'h0, 1, 1, 0);
    endtask

    task automatic test_flush();
        cycle(1, 32'h20, 32'hbbbb_0020, 0, 1, 0);
        cycle(1, 32'h24, 32'hbbbb_0024, 0, 1, 0);
        cycle(1, 32'h28, 32'hbbbb_0028, 0, 1, 1);  // flush with TWO held
        cycle(0, 32'h0,  32'h0, 0, 1, 0);
        cycle(1, 32'h2c, 32'hbbbb_002c, 0, 1, 0);
        cycle(1, 32'h30, 32'hbbbb_0030, 1, 0, 1);  // flush while frozen
        cycle(0, 32'h0,  32'h0, 1, 1, 0);
    endtask

    task automatic test_hold();
        cycle(1, 32'h40, 32'hcccc_0040, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 32'h44, 32'hcccc_0044, 1, 0, 0);
        cycle(0, 32'h0, 32'h0, 1, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            cycle(bit'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 5) != 0),
                  bit'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 1, 0);
    endtask

`ifdef IFID_PERF_EN
    task automatic test_perf();
        do_reset();
        cycle(1, 32'h50, 32'hdddd_0050, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 32'h0, 32'h0, 0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 1, 1);
        cycle(0, 32'h0, 32'h0, 1, 1, 1);
        cycle(0, 32'h0, 32'h0, 1, 1, 0);
        total++;
        if (stall_cnt !== 2'd3 || flush_cnt !== 2'd2) begin
            bad++; $display("FAIL perf_final got=%0d/%0d exp=3/2", stall_cnt, flush_cnt);
        end
    endtask
`endif

    initial begin
        bubble    = '0;
        last_pc   = '0;
        RST_n     = 1'b0;
        IFWrite   = 1'b1;
        Flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        PC_4      = '0;
        Instr     = '0;
`ifdef IFID_PERF_EN
        m_stall = 0; m_flush = 0;
`endif
        @(negedge CLK); @(negedge CLK); #3;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_hold();
        test_random();
`ifdef IFID_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
